// File: rtl/calc_operand_entry.sv
// Operand-entry sequencer: debounces ENTER/CLEAR, captures X, Y and opcode on
// successive ENTER presses and offers the tuple downstream with valid/ready.
module calc_operand_entry #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic       out_ready,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [1:0] op,
    output logic       out_valid,
    output logic       div_by_zero,
    output logic [1:0] state
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_X  = 2'b00,
        GET_Y  = 2'b01,
        GET_OP = 2'b10,
        HOLD   = 2'b11
    } state_t;

    // Handshake: the tuple x/y/op is transferred on a rising edge where
    // out_valid and out_ready are both 1; x/y/op never change while out_valid=1.

    // Button index 0 = ENTER, 1 = CLEAR.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    pulse;
    logic [CW-1:0] cnt [2];
    logic          enter_p;
    logic          clear_p;

    assign raw     = {btn_clear, btn_enter};
    assign enter_p = pulse[0];
    assign clear_p = pulse[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    // Level has been stable long enough: follow it, pulse only on press.
                    if (cnt[i] == CNT_LAST) begin
                        deb[i]   <= sync2[i];
                        cnt[i]   <= '0;
                        pulse[i] <= sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    state_t     state_q;
    state_t     state_d;
    logic [3:0] x_q;
    logic [3:0] x_d;
    logic [3:0] y_q;
    logic [3:0] y_d;
    logic [1:0] op_q;
    logic [1:0] op_d;
    logic       valid_q;
    logic       valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= GET_X;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        valid_d = valid_q;
        // CLEAR overrides both a coincident ENTER and a coincident handshake.
        if (clear_p) begin
            state_d = GET_X;
            x_d     = '0;
            y_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                GET_X: begin
                    if (enter_p) begin
                        x_d     = sw;
                        state_d = GET_Y;
                    end
                end
                GET_Y: begin
                    if (enter_p) begin
                        y_d     = sw;
                        state_d = GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_p) begin
                        op_d    = sw[1:0];
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        state_d = GET_X;
                    end
                end
                default: state_d = GET_X;
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign op          = op_q;
    assign out_valid   = valid_q;
    assign div_by_zero = valid_q & (op_q == 2'b11) & (y_q == 4'd0);
    assign state       = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: vector table of X/Y/opcode entries checked in
// HOLD and through a scoreboard at handshake, plus debounce/clear/reset sequences.
module tb_calc_operand_entry;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] op;
    logic       out_valid;
    logic       div_by_zero;
    logic [1:0] state;

    calc_operand_entry #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter),
        .btn_clear(btn_clear), .out_ready(out_ready), .x(x), .y(y), .op(op),
        .out_valid(out_valid), .div_by_zero(div_by_zero), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sx;
        logic [3:0] sy;
        logic [3:0] sop;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [1:0] eop;
        logic       edbz;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] v, input bit en, input bit clr);
        @(negedge clk);
        sw = v;
        btn_enter = en;
        btn_clear = clr;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Call right after raising a button at a negedge: the next posedge is edge 1.
    task automatic count_edges(input logic [1:0] from, output int edges);
        edges = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (state !== from) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic handshake(input logic [3:0] keep_x);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("hs_valid_low", 32'(out_valid), 32'd0);
        check("hs_state_get_x", 32'(state), 32'd0);
        check("hs_x_kept", 32'(x), 32'(keep_x));
        check("hs_dbz_low", 32'(div_by_zero), 32'd0);
    endtask

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard_unexpected: got 0x%0h, expected no tuple",
                             {x, y, op, div_by_zero});
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_tuple", 32'({x, y, op, div_by_zero}), 32'(e));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[10];
        int   e;

        vt[0] = '{4'h9, 4'h3, 4'b0011, 4'h9, 4'h3, 2'b11, 1'b0};
        vt[1] = '{4'h9, 4'h0, 4'b0011, 4'h9, 4'h0, 2'b11, 1'b1};
        vt[2] = '{4'h5, 4'h0, 4'b0010, 4'h5, 4'h0, 2'b10, 1'b0};
        vt[3] = '{4'hF, 4'hF, 4'b1100, 4'hF, 4'hF, 2'b00, 1'b0};
        vt[4] = '{4'h0, 4'h0, 4'b1111, 4'h0, 4'h0, 2'b11, 1'b1};
        vt[5] = '{4'h7, 4'h2, 4'b0101, 4'h7, 4'h2, 2'b01, 1'b0};
        for (int i = 6; i < 10; i++) begin
            vt[i].sx   = 4'($urandom_range(0, 15));
            vt[i].sy   = 4'($urandom_range(0, 15));
            vt[i].sop  = 4'($urandom_range(0, 15));
            vt[i].ex   = vt[i].sx;
            vt[i].ey   = vt[i].sy;
            vt[i].eop  = vt[i].sop[1:0];
            vt[i].edbz = (vt[i].sop[1:0] == 2'b11) && (vt[i].sy == 4'h0);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_xyop", 32'({x, y, op}), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Press latency: capture lands on edge 3+DB after the press
        sw = 4'h9;
        btn_enter = 1'b1;
        count_edges(2'b00, e);
        check("enter_latency", 32'(e), 32'(DB + 3));
        check("latency_x", 32'(x), 32'h9);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        press(4'h3, 1'b1, 1'b0);
        press(4'b0011, 1'b1, 1'b0);
        check("first_tuple", 32'({x, y, op}), 32'({4'h9, 4'h3, 2'b11}));
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_dbz", 32'(div_by_zero), 32'd0);
        exp_q.push_back({4'h9, 4'h3, 2'b11, 1'b0});
        handshake(4'h9);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            press(vt[i].sx, 1'b1, 1'b0);
            check("vec_state_y", 32'(state), 32'd1);
            press(vt[i].sy, 1'b1, 1'b0);
            check("vec_state_op", 32'(state), 32'd2);
            exp_q.push_back({vt[i].ex, vt[i].ey, vt[i].eop, vt[i].edbz});
            press(vt[i].sop, 1'b1, 1'b0);
            check("vec_state_hold", 32'(state), 32'd3);
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_tuple", 32'({x, y, op}), 32'({vt[i].ex, vt[i].ey, vt[i].eop}));
            check("vec_dbz", 32'(div_by_zero), 32'(vt[i].edbz));
            handshake(vt[i].ex);
        end

        // Bounce rejection: 1,2,3-cycle glitches, then a stable long hold
        @(negedge clk);
        sw = 4'hC;
        for (int w = 1; w <= 3; w++) begin
            btn_enter = 1'b1;
            repeat (w) @(negedge clk);
            btn_enter = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("bounce_no_advance", 32'(state), 32'd0);
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_one_advance", 32'(state), 32'd1);
        check("bounce_x", 32'(x), 32'hC);
        repeat (100) @(negedge clk);
        check("held_no_repeat", 32'(state), 32'd1);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);

        // HOLD ignores ENTER while out_ready is low
        press(4'h5, 1'b1, 1'b0);
        press(4'b0001, 1'b1, 1'b0);
        press(4'hF, 1'b1, 1'b0);
        press(4'hE, 1'b1, 1'b0);
        check("hold_state", 32'(state), 32'd3);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_tuple", 32'({x, y, op}), 32'({4'hC, 4'h5, 2'b01}));
        exp_q.push_back({4'hC, 4'h5, 2'b01, 1'b0});
        handshake(4'hC);

        // Coincident ENTER and CLEAR in GET_OP: clear wins
        press(4'h6, 1'b1, 1'b0);
        press(4'h7, 1'b1, 1'b0);
        press(4'h2, 1'b1, 1'b1);
        check("clr_state", 32'(state), 32'd0);
        check("clr_tuple", 32'({x, y, op}), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);

        // Reset mid-entry with ENTER held: re-debounced, one capture of X
        press(4'hB, 1'b1, 1'b0);
        check("pre_rst_state", 32'(state), 32'd1);
        @(negedge clk);
        sw = 4'hA;
        btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_tuple", 32'({x, y, op}), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        count_edges(2'b00, e);
        check("rst_release_latency", 32'(e), 32'(DB + 3));
        check("rst_release_x", 32'(x), 32'hA);
        repeat (20) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_release_single", 32'(state), 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_operand_entry.md
# calc_operand_entry

Operand-entry sequencer for the 4-bit calculator, directly upstream of the arithmetic units. It debounces the ENTER and CLEAR buttons, captures operand X, operand Y and the operation code from the slide switches in three successive ENTER presses, and presents them with a valid/ready handshake. The arithmetic stage consumes the tuple. The `x`/`y` outputs drive the `x`/`y` inputs of the add/sub/mul/div blocks.

## Interface
- `DB_CYCLES`, default 4: consecutive stable cycles a synchronized button level must hold before the debounced level follows it. Simulation uses 4; the board top overrides it (e.g. 1_000_000). Legal range ≥ 1.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `sw`  in  4  slide switches; operand value, or opcode in `sw[1:0]`.
- `btn_enter`  in  1  raw, asynchronous, bouncy ENTER button (active high).
- `btn_clear`  in  1  raw, asynchronous, bouncy CLEAR button (active high).
- `out_ready`  in  1  downstream accepts the tuple this cycle.
- `x`  out  4  captured operand X.
- `y`  out  4  captured operand Y.
- `op`  out  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `out_valid`  out  1  tuple `x`/`y`/`op` is complete and stable.
- `div_by_zero`  out  1  `out_valid & (op==2'b11) & (y==0)`. Combinational from registers.
- `state`  out  2  current FSM state, for the LEDs.

## Operation
- Button path, identical for each button:
  - Two-flop synchronizer, reset to 0.
  - Stable-count filter. Counter width is `$clog2(DB_CYCLES+1)`.
  - While the synchronized level differs from the debounced level, the counter increments each cycle.
  - On the cycle the counter would reach `DB_CYCLES`, the debounced level toggles and the counter clears.
  - Whenever the levels are equal, the counter clears.
  - The debounced 0→1 transition sets a registered one-cycle pulse (`enter_p`/`clear_p`). Releases are filtered the same way but produce no pulse.
  - A held button yields exactly one pulse.
- FSM states:
  - GET_X = 00
  - GET_Y = 01
  - GET_OP = 10
  - HOLD = 11
- Transitions on `enter_p`:
  - GET_X: `x <= sw`, go to GET_Y.
  - GET_Y: `y <= sw`, go to GET_OP.
  - GET_OP: `op <= sw[1:0]`, `out_valid <= 1`, go to HOLD.
  - HOLD: `enter_p` is ignored.
- Handshake:
  - In HOLD, `out_valid`=1 and `x`/`y`/`op` are frozen.
  - On an edge where `out_valid & out_ready`, clear `out_valid` and go to GET_X.
  - `x`/`y`/`op` keep their values until overwritten.
  - `out_ready` is ignored while `out_valid`=0.
- `clear_p` in any state: `x`,`y`,`op` <= 0, `out_valid` <= 0, go to GET_X.
- Simultaneous `clear_p` and `enter_p`: clear wins, and the enter is dropped.
- Simultaneous `clear_p` and a handshake: clear wins, with the same end state.
- Switch values are sampled unsynchronized at the capture edge. The user holds the switches still while pressing, so no synchronizer is required on `sw`.

## Timing
- Reset (`rst_n`=0 at an edge): state GET_X, `x`=`y`=0, `op`=0, `out_valid`=0, `div_by_zero`=0. Synchronizers, debounced levels, counters and pulses all return to 0.
- Reset mid-operation: any partial entry or pending tuple is discarded.
  - A button still held high when `rst_n` deasserts is re-debounced.
  - It produces one pulse `DB_CYCLES+2` edges after the first edge with `rst_n`=1.
- Press latency:
  - Let `btn` go high before edge 1.
  - The synchronizer output is high after edge 2.
  - The debounced level and pulse are high after edge `2+DB_CYCLES`.
  - The FSM/register update occurs at edge `3+DB_CYCLES`.
- Glitch rejection: a synchronized high lasting fewer than `DB_CYCLES` cycles produces no pulse and leaves the counter at 0 afterwards.
- `out_valid` rises at the GET_OP capture edge and falls at the first edge with `out_ready`=1. Minimum HOLD duration is 1 cycle.
- The earliest next capture of X is the first `enter_p` after returning to GET_X. Presses in HOLD are not queued.

## Test plan
- Reset, then with `DB_CYCLES`=4: press ENTER with `sw`=4'h9, then `sw`=4'h3, then `sw`=4'b0011. Expected: `x`=9, `y`=3, `op`=11, `out_valid`=1, `div_by_zero`=0, each capture at edge 7 after press.
- Same sequence with `y`=0 and `op`=11. Expected: `div_by_zero`=1 while in HOLD. Then assert `out_ready`=1 for one cycle. Expected: `out_valid`=0, `div_by_zero`=0, state GET_X, `x`=9 retained.
- ENTER bounce: pulses of 1, 2 and 3 cycles high separated by lows, then a stable high for 10 cycles. Expected: exactly one capture and one state advance. Holding for 100 cycles gives no further advance.
- In HOLD with `out_ready`=0, press ENTER twice. Expected: state stays HOLD and the tuple is unchanged.
- In GET_OP, press ENTER and CLEAR so their pulses coincide. Expected: state GET_X, `x`=`y`=`op`=0, `out_valid`=0.
- Mid-entry (state GET_Y), assert `rst_n`=0 for one edge while ENTER is held. Expected: all outputs 0, state GET_X. One pulse follows 6 edges after reset release, capturing X.
